// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite response codes, channel FSM encodings and strobe helper.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

    function automatic logic [63:0] strb_mask(input logic [7:0] strb);
        for (int i = 0; i < 8; i++) strb_mask[i*8 +: 8] = {8{strb[i]}};
    endfunction

endpackage

// File: rtl/axil_sram_array.sv
// axil_sram_array: DEPTH x DATA_W storage, one synchronous read port and one byte-strobed write port.
module axil_sram_array
    import axil_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      rd_en,
    input  logic [$clog2(DEPTH)-1:0]  rd_idx,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W/8-1:0]       wr_strb
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mask;

    assign mask = DATA_W'(strb_mask(8'(wr_strb)));

    // Non-blocking update gives read-before-write on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_idx];
        if (wr_en) mem[wr_idx] <= (mem[wr_idx] & ~mask) | (wr_data & mask);
    end

endmodule

// File: rtl/axil_sram_delay.sv
// axil_sram_delay: AXI-Lite slave SRAM with independent read/write channels,
// per-channel response latency and DECERR for addresses outside the window.
module axil_sram_delay
    import axil_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int              BYTES = DATA_W / 8;
    localparam int              OFF_W = $clog2(BYTES);
    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DEPTH * BYTES);

    function automatic logic hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off = a - BASE_ADDR;
        return a >= BASE_ADDR && {1'b0, off} < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off = a - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    rstate_t            rstate, rnext;
    logic [3:0]         rcnt;
    logic [IDX_W-1:0]   ridx, ridx_cur;
    logic               rhit, rhit_cur, ar_hs, r_hs, rd_enter;
    logic [DATA_W-1:0]  rd_q;

    wstate_t              wstate, wnext;
    logic [3:0]           wcnt;
    logic                 aw_held, w_held, aw_hs, w_hs, b_hs, both, wr_enter;
    logic [ADDR_W-1:0]    awaddr_q, waddr_cur;
    logic [DATA_W-1:0]    wdata_q, wdata_cur;
    logic [BYTES-1:0]     wstrb_q, wstrb_cur;

    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign rd_enter = rnext == R_RESP && rstate != R_RESP;
    // At RD_LAT==1 the array is read on the AR edge itself, so decode the live address.
    assign rhit_cur = rstate == R_IDLE ? hit(araddr) : rhit;
    assign ridx_cur = rstate == R_IDLE ? idx_of(araddr) : ridx;
    assign rdata    = (rvalid && rresp == RESP_OKAY) ? rd_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rstate <= R_IDLE;
        else rstate <= rnext;
    end

    always_comb begin
        rnext = (rstate == R_IDLE && ar_hs) ? (RD_LAT == 1 ? R_RESP : R_WAIT)
              : (rstate == R_WAIT && rcnt == 4'd1) ? R_RESP
              : (rstate == R_RESP && r_hs) ? R_IDLE : rstate;
    end

    always_comb begin
        arready = rstate == R_IDLE;
        rvalid  = rstate == R_RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt  <= '0;
            ridx  <= '0;
            rhit  <= 1'b0;
            rresp <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rcnt <= 4'(RD_LAT - 1);
                ridx <= idx_of(araddr);
                rhit <= hit(araddr);
            end else if (rstate == R_WAIT) begin
                rcnt <= rcnt - 4'd1;
            end
            if (rd_enter) rresp <= rhit_cur ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign b_hs      = bvalid && bready;
    assign both      = wstate == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_enter  = wnext == W_RESP && wstate != W_RESP;
    // The completing handshake's payload is not yet latched, so bypass it.
    assign waddr_cur = aw_held ? awaddr_q : awaddr;
    assign wdata_cur = w_held ? wdata_q : wdata;
    assign wstrb_cur = w_held ? wstrb_q : wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wstate <= W_IDLE;
        else wstate <= wnext;
    end

    always_comb begin
        wnext = both ? (WR_LAT == 1 ? W_RESP : W_WAIT)
              : (wstate == W_WAIT && wcnt == 4'd1) ? W_RESP
              : (wstate == W_RESP && b_hs) ? W_IDLE : wstate;
    end

    always_comb begin
        awready = wstate == W_IDLE && !aw_held;
        wready  = wstate == W_IDLE && !w_held;
        bvalid  = wstate == W_RESP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt     <= '0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (both) wcnt <= 4'(WR_LAT - 1);
            else if (wstate == W_WAIT) wcnt <= wcnt - 4'd1;
            if (wr_enter) bresp <= hit(waddr_cur) ? RESP_OKAY : RESP_DECERR;
            if (b_hs) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    axil_sram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .rd_en   (rd_enter),
        .rd_idx  (ridx_cur),
        .rd_data (rd_q),
        .wr_en   (wr_enter && hit(waddr_cur)),
        .wr_idx  (idx_of(waddr_cur)),
        .wr_data (wdata_cur),
        .wr_strb (wstrb_cur)
    );

endmodule

// File: tb/tb_axil_sram_delay.sv
// tb_axil_sram_delay: two DUTs (latency 1/1 and 4/3) driven by directed and random
// AXI-Lite traffic, checked against a word-array memory model.
module tb_axil_sram_delay;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] araddr [2];
    logic        arvalid[2];
    logic        arready[2];
    logic [31:0] rdata  [2];
    logic [1:0]  rresp  [2];
    logic        rvalid [2];
    logic        rready [2];
    logic [31:0] awaddr [2];
    logic        awvalid[2];
    logic        awready[2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic        wvalid [2];
    logic        wready [2];
    logic [1:0]  bresp  [2];
    logic        bvalid [2];
    logic        bready [2];

    bit [31:0] model [2][DEPTH];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axil_sram_delay #(
            .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
            .RD_LAT(g ? 4 : 1), .WR_LAT(g ? 3 : 1)
        ) dut (
            .clk(clk), .rst(rst),
            .araddr(araddr[g]), .arvalid(arvalid[g]), .arready(arready[g]),
            .rdata(rdata[g]), .rresp(rresp[g]), .rvalid(rvalid[g]), .rready(rready[g]),
            .awaddr(awaddr[g]), .awvalid(awvalid[g]), .awready(awready[g]),
            .wdata(wdata[g]), .wstrb(wstrb[g]), .wvalid(wvalid[g]), .wready(wready[g]),
            .bresp(bresp[g]), .bvalid(bvalid[g]), .bready(bready[g])
        );
    end

    function automatic int rlat(input int d);
        return d ? 4 : 1;
    endfunction

    function automatic int wlat(input int d);
        return d ? 3 : 1;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint off = longint'(a) - longint'(BASE);
        return off >= 0 && off < DEPTH * 4;
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [31:0] a);
        return in_rng(a) ? model[d][int'((a - BASE) / 4)] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : 2'b11;
    endfunction

    task automatic mwrite(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        if (in_rng(a))
            for (int i = 0; i < 4; i++)
                if (s[i]) model[d][int'((a - BASE) / 4)][i*8 +: 8] = v[i*8 +: 8];
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(7);
        if (r == 0) return BASE - 32'(4 * $urandom_range(1, 64));
        if (r == 1) return BASE + 32'(DEPTH * 4 + 4 * $urandom_range(0, 64));
        return BASE + 32'(4 * $urandom_range(15) + $urandom_range(3));
    endfunction

    task automatic do_read(input int d, input logic [31:0] a, input int stall,
                           output logic [31:0] data, output logic [1:0] resp);
        int lat;
        araddr[d] = a;
        arvalid[d] = 1'b1;
        @(posedge clk); #1;
        arvalid[d] = 1'b0;
        lat = 1;
        while (rvalid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != rlat(d)) begin
            errors++;
            $display("FAIL rd_latency dut%0d addr=%h got %0d want %0d", d, a, lat, rlat(d));
        end
        data = rdata[d];
        resp = rresp[d];
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (rdata[d] !== data || rresp[d] !== resp || rvalid[d] !== 1'b1 || arready[d] !== 1'b0) begin
                errors++;
                $display("FAIL rd_hold dut%0d rdata=%h rresp=%b rvalid=%b arready=%b want %h %b 1 0",
                         d, rdata[d], rresp[d], rvalid[d], arready[d], data, resp);
            end
            @(posedge clk); #1;
        end
        rready[d] = 1'b1;
        @(posedge clk); #1;
        rready[d] = 1'b0;
        checks++;
        if (rvalid[d] !== 1'b0 || arready[d] !== 1'b1) begin
            errors++;
            $display("FAIL rd_release dut%0d rvalid=%b arready=%b want 0 1", d, rvalid[d], arready[d]);
        end
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] v, input logic [3:0] s,
                            input int gap, input bit wfirst, input int bstall, output logic [1:0] resp);
        int lat;
        awaddr[d] = a;
        wdata[d] = v;
        wstrb[d] = s;
        if (gap == 0) begin
            awvalid[d] = 1'b1;
            wvalid[d] = 1'b1;
        end else if (wfirst) wvalid[d] = 1'b1;
        else awvalid[d] = 1'b1;
        @(posedge clk); #1;
        if (gap > 0) begin
            awvalid[d] = 1'b0;
            wvalid[d] = 1'b0;
            for (int i = 0; i < gap; i++) begin
                checks++;
                if ((wfirst ? wready[d] : awready[d]) !== 1'b0 ||
                    (wfirst ? awready[d] : wready[d]) !== 1'b1 || bvalid[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_split_ready dut%0d awready=%b wready=%b bvalid=%b wfirst=%0d",
                             d, awready[d], wready[d], bvalid[d], wfirst);
                end
                if (i == gap - 1) begin
                    if (wfirst) awvalid[d] = 1'b1;
                    else wvalid[d] = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        awvalid[d] = 1'b0;
        wvalid[d] = 1'b0;
        lat = 1;
        while (bvalid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != wlat(d)) begin
            errors++;
            $display("FAIL wr_latency dut%0d addr=%h got %0d want %0d", d, a, lat, wlat(d));
        end
        resp = bresp[d];
        for (int i = 0; i < bstall; i++) begin
            checks++;
            if (bvalid[d] !== 1'b1 || bresp[d] !== resp || awready[d] !== 1'b0 || wready[d] !== 1'b0) begin
                errors++;
                $display("FAIL wr_hold dut%0d bvalid=%b bresp=%b awready=%b wready=%b want 1 %b 0 0",
                         d, bvalid[d], bresp[d], awready[d], wready[d], resp);
            end
            @(posedge clk); #1;
        end
        bready[d] = 1'b1;
        @(posedge clk); #1;
        bready[d] = 1'b0;
        checks++;
        if (bvalid[d] !== 1'b0 || awready[d] !== 1'b1 || wready[d] !== 1'b1) begin
            errors++;
            $display("FAIL wr_release dut%0d bvalid=%b awready=%b wready=%b want 0 1 1",
                     d, bvalid[d], awready[d], wready[d]);
        end
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({arready[d], awready[d], wready[d], rvalid[d], bvalid[d]} !== 5'b11100 ||
                rdata[d] !== 32'h0 || rresp[d] !== 2'b00 || bresp[d] !== 2'b00) begin
                errors++;
                $display("FAIL reset_state dut%0d ready/valid=%b%b%b%b%b rdata=%h rresp=%b bresp=%b want 11100 0 00 00",
                         d, arready[d], awready[d], wready[d], rvalid[d], bvalid[d], rdata[d], rresp[d], bresp[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_init();
        logic [1:0] r;
        logic [31:0] v;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i <= 16; i++) begin
                int idx = (i == 16) ? DEPTH - 1 : i;
                v = $urandom;
                do_write(d, BASE + 32'(idx * 4), v, 4'hF, 0, 1'b0, 0, r);
                mwrite(d, BASE + 32'(idx * 4), v, 4'hF);
                checks++;
                if (r !== 2'b00) begin
                    errors++;
                    $display("FAIL init_bresp dut%0d idx=%0d got %b want 00", d, idx, r);
                end
            end
    endtask

    task automatic test_basic();
        logic [1:0] r;
        logic [31:0] v;
        do_write(0, 32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0, r);
        mwrite(0, 32'h8000_0010, 32'hDEADBEEF, 4'hF);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b want 00", r); end
        do_read(0, 32'h8000_0010, 0, v, r);
        checks++;
        if (v !== 32'hDEADBEEF || r !== 2'b00) begin
            errors++;
            $display("FAIL basic_read got %h/%b want deadbeef/00", v, r);
        end
        do_write(0, 32'h8000_0010, 32'h11223344, 4'h5, 0, 1'b0, 0, r);
        mwrite(0, 32'h8000_0010, 32'h11223344, 4'h5);
        do_read(0, 32'h8000_0010, 0, v, r);
        checks++;
        if (v !== 32'hDE22BE44 || r !== 2'b00) begin
            errors++;
            $display("FAIL partial_strobe got %h/%b want de22be44/00", v, r);
        end
        do_write(0, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, 0, r);
        do_read(0, 32'h8000_0010, 0, v, r);
        checks++;
        if (v !== 32'hDE22BE44 || r !== 2'b00) begin
            errors++;
            $display("FAIL zero_strobe got %h/%b want de22be44/00", v, r);
        end
    endtask

    task automatic test_latency();
        logic [1:0] r;
        logic [31:0] v, n;
        n = $urandom;
        do_write(1, BASE + 32'h40, n, 4'hF, 2, 1'b0, 2, r);
        mwrite(1, BASE + 32'h40, n, 4'hF);
        n = $urandom;
        do_write(1, BASE + 32'h44, n, 4'hF, 1, 1'b1, 0, r);
        mwrite(1, BASE + 32'h44, n, 4'hF);
        do_read(1, BASE + 32'h40, 5, v, r);
        checks++;
        if (v !== exp_rd(1, BASE + 32'h40) || r !== 2'b00) begin
            errors++;
            $display("FAIL latency_read40 got %h/%b want %h/00", v, r, exp_rd(1, BASE + 32'h40));
        end
        do_read(1, BASE + 32'h44, 0, v, r);
        checks++;
        if (v !== exp_rd(1, BASE + 32'h44) || r !== 2'b00) begin
            errors++;
            $display("FAIL latency_read44 got %h/%b want %h/00", v, r, exp_rd(1, BASE + 32'h44));
        end
    endtask

    task automatic test_decerr();
        logic [1:0] r;
        logic [31:0] v;
        logic [31:0] last = BASE + 32'((DEPTH - 1) * 4);
        for (int d = 0; d < 2; d++) begin
            do_read(d, 32'h7FFF_FFFC, 1, v, r);
            checks++;
            if (v !== 32'h0 || r !== 2'b11) begin
                errors++;
                $display("FAIL decerr_read dut%0d got %h/%b want 0/11", d, v, r);
            end
            do_write(d, BASE + 32'(DEPTH * 4), $urandom, 4'hF, 0, 1'b0, 0, r);
            checks++;
            if (r !== 2'b11) begin
                errors++;
                $display("FAIL decerr_write dut%0d got %b want 11", d, r);
            end
            do_read(d, last, 0, v, r);
            checks++;
            if (v !== exp_rd(d, last) || r !== 2'b00) begin
                errors++;
                $display("FAIL last_word dut%0d got %h/%b want %h/00", d, v, r, exp_rd(d, last));
            end
        end
    endtask

    task automatic test_collision();
        logic [1:0] r, wr;
        logic [31:0] v;
        for (int d = 0; d < 2; d++) begin
            do_write(d, 32'h8000_0020, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 0, r);
            mwrite(d, 32'h8000_0020, 32'hA5A5A5A5, 4'hF);
            // DUT1 read samples at AR+3 edges; a write completing one edge later commits on that same edge.
            fork
                do_read(d, 32'h8000_0020, 0, v, r);
                begin
                    if (d == 1) begin @(posedge clk); #1; end
                    do_write(d, 32'h8000_0020, 32'h0, 4'hF, 0, 1'b0, 0, wr);
                end
            join
            checks++;
            if (v !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL collision_old dut%0d got %h want a5a5a5a5", d, v);
            end
            mwrite(d, 32'h8000_0020, 32'h0, 4'hF);
            do_read(d, 32'h8000_0020, 0, v, r);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL collision_new dut%0d got %h want 00000000", d, v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        logic [31:0] v;
        logic [31:0] a = BASE + 32'h14;
        awaddr[1] = a;
        wdata[1] = ~exp_rd(1, a);
        wstrb[1] = 4'hF;
        awvalid[1] = 1'b1;
        wvalid[1] = 1'b1;
        @(posedge clk); #1;
        awvalid[1] = 1'b0;
        wvalid[1] = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({arready[1], awready[1], wready[1], rvalid[1], bvalid[1]} !== 5'b11100 || bresp[1] !== 2'b00) begin
            errors++;
            $display("FAIL async_reset ready/valid=%b%b%b%b%b bresp=%b want 11100 00",
                     arready[1], awready[1], wready[1], rvalid[1], bvalid[1], bresp[1]);
        end
        @(posedge clk); #4;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bvalid[1] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_bvalid cycle %0d got %b want 0", i, bvalid[1]);
            end
        end
        do_read(1, a, 0, v, r);
        checks++;
        if (v !== exp_rd(1, a)) begin
            errors++;
            $display("FAIL reset_no_commit got %h want %h", v, exp_rd(1, a));
        end
    endtask

    task automatic test_random();
        logic [1:0] r, wr;
        logic [31:0] v, a, a2, n, e;
        logic [3:0] s;
        for (int k = 0; k < 150; k++) begin
            int d = $urandom_range(1);
            int op = $urandom_range(2);
            a = rand_addr();
            n = $urandom;
            s = 4'($urandom);
            if (op == 0) begin
                do_write(d, a, n, s, $urandom_range(2), 1'($urandom), $urandom_range(2), r);
                mwrite(d, a, n, s);
                checks++;
                if (r !== exp_resp(a)) begin
                    errors++;
                    $display("FAIL rand_bresp dut%0d addr=%h got %b want %b", d, a, r, exp_resp(a));
                end
            end else if (op == 1) begin
                e = exp_rd(d, a);
                do_read(d, a, $urandom_range(3), v, r);
                checks++;
                if (v !== e || r !== exp_resp(a)) begin
                    errors++;
                    $display("FAIL rand_read dut%0d addr=%h got %h/%b want %h/%b", d, a, v, r, e, exp_resp(a));
                end
            end else begin
                a2 = in_rng(a) ? BASE + 32'((((a - BASE) / 4 + 1) % 16) * 4) : rand_addr();
                e = exp_rd(d, a);
                fork
                    do_read(d, a, $urandom_range(2), v, r);
                    do_write(d, a2, n, s, $urandom_range(2), 1'($urandom), $urandom_range(2), wr);
                join
                mwrite(d, a2, n, s);
                checks++;
                if (v !== e || r !== exp_resp(a) || wr !== exp_resp(a2)) begin
                    errors++;
                    $display("FAIL rand_concurrent dut%0d raddr=%h waddr=%h got %h/%b/%b want %h/%b/%b",
                             d, a, a2, v, r, wr, e, exp_resp(a), exp_resp(a2));
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
            awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0;
            wvalid[d] = 1'b0; bready[d] = 1'b0;
        end
        test_reset();
        test_init();
        test_basic();
        test_latency();
        test_decerr();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout after %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
